// File: rtl/conv_pkg.sv
// Shared types for the 2x2 convolution window stages.
package conv_pkg;

  localparam int unsigned CONV_PIX_W = 8;

  typedef struct packed {
    logic [CONV_PIX_W-1:0] p00;
    logic [CONV_PIX_W-1:0] p01;
    logic [CONV_PIX_W-1:0] p10;
    logic [CONV_PIX_W-1:0] p11;
  } conv_win_t;

  typedef enum logic {
    S_ROW0,
    S_STREAM
  } conv_state_t;

endpackage

// File: rtl/conv_line_buf.sv
// Single-port line RAM: asynchronous read, synchronous write at the same address.
module conv_line_buf #(
  parameter int unsigned DEPTH  = 640,
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  output logic [WIDTH-1:0]  rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // NOTE: the array has no reset; every entry is written by row 0 before any read uses it.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/conv_window_gen.sv
// Raster pixel stream to 2x2 windows with one line of history and a registered output.
// Define CONV_WINDOW_ZERO_PAD_EN to emit a zero-padded window for every pixel.
module conv_window_gen
  import conv_pkg::*;
#(
  parameter int unsigned IMG_W = 640,
  parameter int unsigned IMG_H = 360,
  parameter int unsigned PIX_W = CONV_PIX_W
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [PIX_W-1:0]   pixel_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [4*PIX_W-1:0] win_o,
  output logic               last_o
);

  localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_H - 1);

  logic [COL_W-1:0]   col_q, col_d;
  logic [ROW_W-1:0]   row_q, row_d;
  conv_state_t        state_q, state_d;
  logic [PIX_W-1:0]   top_prev_q, cur_prev_q;
  logic               valid_q, last_q;
  logic [4*PIX_W-1:0] win_q;

  logic               accept, col_wrap, frame_end, emit;
  logic [PIX_W-1:0]   old_pix, tap_tl, tap_tr, tap_bl;

  assign ready_o   = !valid_q || ready_i;
  assign accept    = valid_i && ready_o;
  assign col_wrap  = (col_q == COL_MAX);
  assign frame_end = col_wrap && (row_q == ROW_MAX);

  conv_line_buf #(
    .DEPTH  (IMG_W),
    .WIDTH  (PIX_W),
    .ADDR_W (COL_W)
  ) u_line_buf (
    .clk_i   (clk_i),
    .we_i    (accept),
    .addr_i  (col_q),
    .wdata_i (pixel_i),
    .rdata_o (old_pix)
  );

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    state_d = state_q;
    if (accept) begin
      if (col_wrap) begin
        col_d = '0;
        row_d = (row_q == ROW_MAX) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
    case (state_q)
      S_ROW0:   if (accept && col_wrap) state_d = S_STREAM;
      S_STREAM: if (accept && frame_end) state_d = S_ROW0;
      default:  state_d = S_ROW0;
    endcase
  end

  always_comb begin
    tap_tl = top_prev_q;
    tap_tr = old_pix;
    tap_bl = cur_prev_q;
`ifdef CONV_WINDOW_ZERO_PAD_EN
    // Row 0 has no line above; column 0 has no pixel to its left.
    emit = accept;
    if (state_q == S_ROW0) begin
      tap_tl = '0;
      tap_tr = '0;
    end
    if (col_q == '0) begin
      tap_tl = '0;
      tap_bl = '0;
    end
`else
    emit = accept && (state_q == S_STREAM) && (col_q != '0);
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      col_q      <= '0;
      row_q      <= '0;
      state_q    <= S_ROW0;
      top_prev_q <= '0;
      cur_prev_q <= '0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      state_q <= state_d;
      if (accept) begin
        top_prev_q <= old_pix;
        cur_prev_q <= pixel_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      win_q   <= '0;
      last_q  <= 1'b0;
    end else if (emit) begin
      valid_q <= 1'b1;
      win_q   <= {tap_tl, tap_tr, tap_bl, pixel_i};
      last_q  <= frame_end;
    end else if (ready_i) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign win_o   = win_q;
  assign last_o  = last_q;

endmodule
